// File: rtl/prescaled_multi_timer.sv
//
// prescaled_multi_timer
//
// A shared prescaler produces a tick every (psc+1) enabled clocks. NCH
// independent down-counter channels step on that tick. Each channel loads
// its reload value on start, counts down to 0, and on the tick that finds
// cnt = 0 it expires. Expiry raises a one-cycle done pulse and sets a sticky
// irq flag. A one-shot channel then parks in IDLE with cnt = 0. An
// auto-reload channel reloads and keeps running.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low reset
//   en       in   global prescaler enable (en = 0 freezes every channel)
//   psc      in   [PSC_W]      prescale compare; tick period = psc+1 clocks
//   start    in   [NCH]        per-channel start / restart strobe
//   stop     in   [NCH]        per-channel stop strobe (beats start)
//   oneshot  in   [NCH]        1 = one-shot, 0 = auto-reload (read at expiry)
//   reload   in   [NCH*CNT_W]  channel i reload is bits [i*CNT_W +: CNT_W]
//   irq_clr  in   [NCH]        per-channel irq clear (loses to a new expiry)
//   tick     out               combinational prescaler tick
//   cnt      out  [NCH*CNT_W]  per-channel current count
//   running  out  [NCH]        channel is in RUN
//   done     out  [NCH]        registered one-cycle expiry pulse
//   irq      out  [NCH]        sticky expiry flag
//
module prescaled_multi_timer #(
    parameter int CNT_W = 16,
    parameter int PSC_W = 5,
    parameter int NCH   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [PSC_W-1:0]       psc,
    input  logic [NCH-1:0]         start,
    input  logic [NCH-1:0]         stop,
    input  logic [NCH-1:0]         oneshot,
    input  logic [NCH*CNT_W-1:0]   reload,
    input  logic [NCH-1:0]         irq_clr,
    output logic                   tick,
    output logic [NCH*CNT_W-1:0]   cnt,
    output logic [NCH-1:0]         running,
    output logic [NCH-1:0]         done,
    output logic [NCH-1:0]         irq
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Shared prescaler
    // ------------------------------------------------------------------
    logic [PSC_W-1:0] psc_cnt_reg;
    logic [PSC_W-1:0] psc_cnt_next;

    // The >= compare lets a lowered psc take effect at once instead of
    // waiting for psc_cnt to wrap. Gating with reset keeps tick low while
    // the block is held in reset, even when psc = 0.
    assign tick = reset && en && (psc_cnt_reg >= psc);

    // psc_cnt never passes psc, so the increment cannot wrap.
    always_comb begin
        psc_cnt_next = psc_cnt_reg;
        if (en) begin
            if (tick) begin
                psc_cnt_next = '0;
            end else begin
                psc_cnt_next = PSC_W'(psc_cnt_reg + 1'b1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_cnt_reg <= '0;
        end else begin
            psc_cnt_reg <= psc_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            state_t             state_reg;
            state_t             state_next;
            logic [CNT_W-1:0]   cnt_reg;
            logic [CNT_W-1:0]   cnt_next;
            logic               done_reg;
            logic               done_next;
            logic               irq_reg;
            logic               irq_next;
            logic [CNT_W-1:0]   reload_ch;
            logic               expire;

            assign reload_ch = reload[gi*CNT_W +: CNT_W];

            // Expiry only when nothing with higher priority acts this cycle.
            assign expire = (state_reg == ST_RUN) && !stop[gi] && !start[gi]
                            && tick && (cnt_reg == '0);

            // State register
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    done_reg  <= 1'b0;
                    irq_reg   <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    done_reg  <= done_next;
                    irq_reg   <= irq_next;
                end
            end

            // Next-state logic: stop > start > tick
            always_comb begin
                state_next = state_reg;
                if (stop[gi]) begin
                    state_next = ST_IDLE;
                end else if (start[gi]) begin
                    state_next = ST_RUN;
                end else if (expire && oneshot[gi]) begin
                    state_next = ST_IDLE;
                end
            end

            // Output / datapath logic
            always_comb begin
                cnt_next  = cnt_reg;
                done_next = expire;
                // A new expiry wins over a coincident clear.
                irq_next  = expire | (irq_reg & ~irq_clr[gi]);
                if (stop[gi]) begin
                    // Stopped channels keep their count so software can read it.
                    cnt_next = cnt_reg;
                end else if (start[gi]) begin
                    cnt_next = reload_ch;
                end else if ((state_reg == ST_RUN) && tick) begin
                    if (cnt_reg != '0) begin
                        cnt_next = CNT_W'(cnt_reg - 1'b1);
                    end else if (!oneshot[gi]) begin
                        // Reload value is sampled at expiry, not at start.
                        cnt_next = reload_ch;
                    end
                end
            end

            assign cnt[gi*CNT_W +: CNT_W] = cnt_reg;
            assign running[gi]            = (state_reg == ST_RUN);
            assign done[gi]               = done_reg;
            assign irq[gi]                = irq_reg;
        end
    endgenerate

endmodule

// File: tb/tb_prescaled_multi_timer.sv
//
// Testbench for prescaled_multi_timer: directed scenarios followed by a
// randomized phase, all checked each cycle against a behavioural model.
//
module tb_prescaled_multi_timer;

    localparam int CNT_W = 16;
    localparam int PSC_W = 5;
    localparam int NCH   = 2;

    logic                   clk;
    logic                   reset;
    logic                   en;
    logic [PSC_W-1:0]       psc;
    logic [NCH-1:0]         start;
    logic [NCH-1:0]         stop;
    logic [NCH-1:0]         oneshot;
    logic [NCH*CNT_W-1:0]   reload;
    logic [NCH-1:0]         irq_clr;
    logic                   tick;
    logic [NCH*CNT_W-1:0]   cnt;
    logic [NCH-1:0]         running;
    logic [NCH-1:0]         done;
    logic [NCH-1:0]         irq;

    prescaled_multi_timer #(
        .CNT_W (CNT_W),
        .PSC_W (PSC_W),
        .NCH   (NCH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .psc     (psc),
        .start   (start),
        .stop    (stop),
        .oneshot (oneshot),
        .reload  (reload),
        .irq_clr (irq_clr),
        .tick    (tick),
        .cnt     (cnt),
        .running (running),
        .done    (done),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: a channel is "armed" with a number of ticks still
    // to see before it expires; the visible count is that number.
    int m_psc_cnt;
    int m_cnt  [NCH];
    bit m_run  [NCH];
    bit m_done [NCH];
    bit m_irq  [NCH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_tick();
        return (en === 1'b1) && (m_psc_cnt >= int'(psc));
    endfunction

    task automatic m_reset();
        m_psc_cnt = 0;
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_run[c] = 0; m_done[c] = 0; m_irq[c] = 0;
        end
    endtask

    task automatic set_reload(input int c, input int v);
        reload[c*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    task automatic compare_all();
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("cnt%0d", c),     32'(cnt[c*CNT_W +: CNT_W]), 32'(m_cnt[c]));
            check($sformatf("running%0d", c), 32'(running[c]),            32'(m_run[c]));
            check($sformatf("done%0d", c),    32'(done[c]),               32'(m_done[c]));
            check($sformatf("irq%0d", c),     32'(irq[c]),                32'(m_irq[c]));
        end
    endtask

    // One clock: check tick, advance the model with the current inputs,
    // cross the edge and compare every registered output.
    task automatic step();
        bit t;
        bit exp_fire;
        int r;
        #1;
        t = m_tick();
        check("tick", 32'(tick), 32'(t));
        if (en === 1'b1) m_psc_cnt = t ? 0 : m_psc_cnt + 1;
        for (int c = 0; c < NCH; c++) begin
            r = int'(reload[c*CNT_W +: CNT_W]);
            exp_fire = 0;
            if (stop[c]) begin
                m_run[c] = 0;
            end else if (start[c]) begin
                m_cnt[c] = r;
                m_run[c] = 1;
            end else if (m_run[c] && t) begin
                if (m_cnt[c] > 0) m_cnt[c] = m_cnt[c] - 1;
                else begin
                    exp_fire = 1;
                    if (oneshot[c]) m_run[c] = 0;
                    else m_cnt[c] = r;
                end
            end
            m_done[c] = exp_fire;
            if (exp_fire) m_irq[c] = 1;
            else if (irq_clr[c]) m_irq[c] = 0;
        end
        @(posedge clk);
        #1;
        compare_all();
        $display("cyc t=%0t en=%0b psc=%0d start=%b stop=%b cnt0=%0d cnt1=%0d run=%b done=%b irq=%b",
                 $time, en, psc, start, stop, cnt[0 +: CNT_W], cnt[CNT_W +: CNT_W], running, done, irq);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tick"},    32'(tick),    32'd0);
        check({tag, "_cnt"},     32'(cnt),     32'd0);
        check({tag, "_running"}, 32'(running), 32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
        check({tag, "_irq"},     32'(irq),     32'd0);
    endtask

    initial begin
        int pulses;
        bit found;

        reset = 1'b0; en = 1'b1; psc = '0;
        start = '0; stop = '0; oneshot = '0; reload = '0; irq_clr = '0;
        m_reset();

        // Held in reset: everything zero, tick gated even with psc = 0.
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        // Prescaler: psc = 3 ticks every 4th cycle; freeze with en = 0.
        psc = 5'd3;
        repeat (12) step();
        en = 1'b0;
        repeat (5) step();
        en = 1'b1;
        repeat (6) step();

        // Ch0 auto-reload, reload = 2, psc = 0.
        psc = 5'd0; oneshot = 2'b00; set_reload(0, 2);
        start[0] = 1'b1; step(); start[0] = 1'b0;
        check("ar_start_cnt", 32'(cnt[0 +: CNT_W]), 32'd2);
        pulses = 0;
        for (int k = 0; k < 9; k++) begin
            step();
            pulses += int'(done[0]);
        end
        check("ar_pulses", 32'(pulses), 32'd3);
        check("ar_irq_sticky", 32'(irq[0]), 32'd1);
        irq_clr[0] = 1'b1; step(); irq_clr[0] = 1'b0;

        // irq_clr on the expiry cycle: set wins.
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_run[0] && m_cnt[0] == 0 && m_tick()) found = 1;
            else step();
        end
        check("find_expiry", 32'(found), 32'd1);
        irq_clr[0] = 1'b1; step(); irq_clr[0] = 1'b0;
        check("clr_vs_set_irq", 32'(irq[0]), 32'd1);
        check("clr_vs_set_done", 32'(done[0]), 32'd1);

        // start on a tick at cnt = 0: reload, no done.
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_run[0] && m_cnt[0] == 0 && m_tick()) found = 1;
            else step();
        end
        check("find_expiry2", 32'(found), 32'd1);
        start[0] = 1'b1; step(); start[0] = 1'b0;
        check("restart_done", 32'(done[0]), 32'd0);
        check("restart_cnt", 32'(cnt[0 +: CNT_W]), 32'd2);
        stop[0] = 1'b1; step(); stop[0] = 1'b0;

        // Ch1 one-shot, reload = 4, psc = 1: one pulse, then parked at 0.
        psc = 5'd1; oneshot[1] = 1'b1; set_reload(1, 4);
        start[1] = 1'b1; step(); start[1] = 1'b0;
        pulses = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            pulses += int'(done[1]);
        end
        check("os_pulses", 32'(pulses), 32'd1);
        check("os_running", 32'(running[1]), 32'd0);
        check("os_cnt", 32'(cnt[CNT_W +: CNT_W]), 32'd0);

        // stop at cnt = 5 holds the count; start+stop together: stop wins.
        psc = 5'd0; set_reload(0, 9);
        start[0] = 1'b1; step(); start[0] = 1'b0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_cnt[0] == 5) found = 1;
            else step();
        end
        check("find_cnt5", 32'(found), 32'd1);
        stop[0] = 1'b1; step(); stop[0] = 1'b0;
        check("stop_cnt", 32'(cnt[0 +: CNT_W]), 32'd5);
        check("stop_running", 32'(running[0]), 32'd0);
        start[0] = 1'b1; stop[0] = 1'b1; step(); start[0] = 1'b0; stop[0] = 1'b0;
        check("startstop_running", 32'(running[0]), 32'd0);
        check("startstop_cnt", 32'(cnt[0 +: CNT_W]), 32'd5);

        // Asynchronous reset mid-count with cnt = 7 and irq = 1.
        start[0] = 1'b1; step(); start[0] = 1'b0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_cnt[0] == 7) found = 1;
            else step();
        end
        check("find_cnt7", 32'(found), 32'd1);
        check("pre_reset_irq", 32'(irq[0]), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_reset();

        // Reload = 0 auto-reload, psc = 2: done on every tick.
        psc = 5'd2; oneshot = 2'b00; set_reload(0, 0);
        start[0] = 1'b1; step(); start[0] = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            pulses += int'(done[0]);
        end
        check("r0_pulses", 32'(pulses), 32'd4);

        // Randomized phase against the model.
        for (int k = 0; k < 600; k++) begin
            if (k % 25 == 0) psc = PSC_W'($urandom_range(0, 3));
            en = ($urandom_range(0, 9) != 0);
            for (int c = 0; c < NCH; c++) begin
                start[c]   = ($urandom_range(0, 11) == 0);
                stop[c]    = ($urandom_range(0, 23) == 0);
                irq_clr[c] = ($urandom_range(0, 7) == 0);
                oneshot[c] = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 5) == 0) set_reload(c, int'($urandom_range(0, 5)));
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
